// File: rtl/zclk_phase_gen.sv
// ============================================================================
// Module      : zclk_phase_gen
// Description : 28 MHz -> 7/14 MHz phase strobe generator and Z80 turbo-switch
//               arbiter. Turbo changes are deferred until a refresh cycle (or a
//               timeout) and always take effect on a c3 boundary.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zclk_phase_gen #(
  parameter logic [1:0]  TURBO_RST = 2'b00,    // turbo after reset (00=3.5, 01=7, 1x=14 MHz)
  parameter logic [15:0] TIMEOUT   = 16'd4096  // c3 periods before forced switch, 0 = never
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] turbo_req,
  input  logic       rfsh_n,
  output logic       c0,
  output logic       c1,
  output logic       c2,
  output logic       c3,
  output logic       f0,
  output logic       f1,
  output logic [1:0] turbo,
  output logic       turbo_busy,
  output logic       turbo_chg
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic        TMO_EN   = (TIMEOUT != 16'd0);
  localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;
  localparam logic [15:0] TMR_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_ARM  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Phase counter and strobes
  // --------------------------------------------------------------------------
  logic [1:0] ph_q;
  logic [1:0] ph_d;
  logic [3:0] c_q;
  logic [3:0] c_d;
  logic [1:0] f_q;
  logic [1:0] f_d;

  // Next phase: strobes are decoded from the incremented phase so that the
  // registered one-hot value always matches the phase being entered.
  always_comb begin
    ph_d = ph_q + 2'd1;
    c_d  = 4'b0001 << ph_d;
    f_d  = {c_d[1] | c_d[3], c_d[0] | c_d[2]};
  end

  // Free-running phase register; reset parks at 3 so the first edge yields c0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= 2'd3;
      c_q  <= 4'b0000;
      f_q  <= 2'b00;
    end else begin
      ph_q <= ph_d;
      c_q  <= c_d;
      f_q  <= f_d;
    end
  end

  // --------------------------------------------------------------------------
  // RFSH_n synchroniser and falling-edge detector
  // --------------------------------------------------------------------------
  logic rfsh_meta_q;
  logic rfsh_sync_q;
  logic rfsh_dly_q;
  logic rfsh_fall_q;

  // Two-flop synchroniser followed by a registered 1->0 edge detect
  // (pin fall to pulse is three clocks).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rfsh_meta_q <= 1'b1;
      rfsh_sync_q <= 1'b1;
      rfsh_dly_q  <= 1'b1;
      rfsh_fall_q <= 1'b0;
    end else begin
      rfsh_meta_q <= rfsh_n;
      rfsh_sync_q <= rfsh_meta_q;
      rfsh_dly_q  <= rfsh_sync_q;
      rfsh_fall_q <= rfsh_dly_q & ~rfsh_sync_q;
    end
  end

  // --------------------------------------------------------------------------
  // Turbo switch arbiter
  // --------------------------------------------------------------------------
  state_t      state_q;
  logic [1:0]  tgt_q;
  logic [15:0] timer_q;
  logic [1:0]  turbo_q;
  logic        turbo_chg_q;
  logic        tmo_hit;

  // Timeout fires on the c3 edge that would complete the last waiting period.
  assign tmo_hit = TMO_EN && c_q[3] && (timer_q == TMO_LAST);

  // Request tracking: IDLE detects a mismatch, PEND follows the latest request
  // until refresh/timeout, ARM freezes the target and commits it on c3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tgt_q       <= TURBO_RST;
      timer_q     <= 16'd0;
      turbo_q     <= TURBO_RST;
      turbo_chg_q <= 1'b0;
    end else begin
      turbo_chg_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (turbo_req != turbo_q) begin
            state_q <= S_PEND;
            tgt_q   <= turbo_req;
            timer_q <= 16'd0;
          end
        end
        S_PEND: begin
          if (turbo_req == turbo_q) begin
            // Request withdrawn before it could be applied.
            state_q <= S_IDLE;
          end else begin
            tgt_q <= turbo_req;
            if (rfsh_fall_q || tmo_hit) begin
              state_q <= S_ARM;
            end else if (c_q[3] && (timer_q != TMR_MAX)) begin
              timer_q <= timer_q + 16'd1;
            end
          end
        end
        S_ARM: begin
          // Commit on the last clock of the 7 MHz period so the new setting
          // starts cleanly with the following c0.
          if (c_q[3]) begin
            turbo_q     <= tgt_q;
            turbo_chg_q <= (tgt_q != turbo_q);
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign c0         = c_q[0];
  assign c1         = c_q[1];
  assign c2         = c_q[2];
  assign c3         = c_q[3];
  assign f0         = f_q[0];
  assign f1         = f_q[1];
  assign turbo      = turbo_q;
  assign turbo_busy = (state_q != S_IDLE);
  assign turbo_chg  = turbo_chg_q;

endmodule

`default_nettype wire

// File: tb/tb_zclk_phase_gen.sv
// ============================================================================
// Module      : tb_zclk_phase_gen
// Description : Self-checking bench for zclk_phase_gen. A cycle model pushes
//               the expected outputs on every clock; each test task pops and
//               compares them, plus scenario-specific checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zclk_phase_gen;

  localparam logic [1:0]  TR  = 2'b00;
  localparam logic [15:0] TMO = 16'd8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] turbo_req;
  logic       rfsh_n;
  logic       c0, c1, c2, c3, f0, f1;
  logic [1:0] turbo;
  logic       turbo_busy, turbo_chg;
  logic [9:0] outs;

  int total = 0;
  int bad   = 0;

  zclk_phase_gen #(.TURBO_RST(TR), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .turbo_req(turbo_req), .rfsh_n(rfsh_n),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .f0(f0), .f1(f1),
    .turbo(turbo), .turbo_busy(turbo_busy), .turbo_chg(turbo_chg)
  );

  always #18 clk = ~clk;

  assign outs = {c0, c1, c2, c3, f0, f1, turbo, turbo_busy, turbo_chg};

  // --------------------------------------------------------------------------
  // Behavioural model and scoreboard queue
  // --------------------------------------------------------------------------
  logic [9:0]  exp_q[$];
  logic [1:0]  m_ph;
  logic [3:0]  m_c;
  logic [1:0]  m_turbo, m_tgt;
  int          m_st;          // 0 idle, 1 pending, 2 armed
  logic [15:0] m_tmr;
  logic        m_s1, m_s2, m_s3, m_fall, m_chg;
  logic        o_c3, o_fall, n_chg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 2'd3; m_c = 4'b0; m_turbo = TR; m_tgt = TR; m_st = 0; m_tmr = 16'd0;
      m_s1 = 1'b1; m_s2 = 1'b1; m_s3 = 1'b1; m_fall = 1'b0; m_chg = 1'b0;
      exp_q.delete();
    end else begin
      o_c3   = m_c[3];
      o_fall = m_fall;
      n_chg  = 1'b0;
      if (m_st == 0) begin
        if (turbo_req != m_turbo) begin m_st = 1; m_tgt = turbo_req; m_tmr = 16'd0; end
      end else if (m_st == 1) begin
        if (turbo_req == m_turbo) m_st = 0;
        else begin
          m_tgt = turbo_req;
          if (o_fall) m_st = 2;
          else if (o_c3 && m_tmr == TMO - 16'd1) m_st = 2;
          else if (o_c3 && m_tmr != 16'hFFFF) m_tmr = m_tmr + 16'd1;
        end
      end else begin
        if (o_c3) begin n_chg = (m_tgt != m_turbo); m_turbo = m_tgt; m_st = 0; end
      end
      m_chg  = n_chg;
      m_fall = m_s3 & ~m_s2;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = rfsh_n;
      m_ph = m_ph + 2'd1;
      m_c  = 4'b0001 << m_ph;
      exp_q.push_back({m_c[0], m_c[1], m_c[2], m_c[3], m_c[0] | m_c[2], m_c[1] | m_c[3],
                       m_turbo, (m_st != 0), m_chg});
    end
  end

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [9:0] e;
    rst_n = 1'b0; turbo_req = TR; rfsh_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (outs !== {6'b0, TR, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_state got=%b want=%b", outs, {6'b0, TR, 2'b00});
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total++;
      if (outs !== e) begin bad++; $display("FAIL reset_release got=%b want=%b", outs, e); end
    end
    total++;
    if ({c0, c1, c2, c3, f0, f1} !== 6'b100010) begin
      bad++; $display("FAIL first_edge_c0 got=%b want=%b", {c0, c1, c2, c3, f0, f1}, 6'b100010);
    end
  endtask

  task automatic test_phase();
    logic [9:0] e;
    logic [3:0] prev;
    prev = {c0, c1, c2, c3};
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); total++;
        if (outs !== e) begin bad++; $display("FAIL phase[%0d] got=%b want=%b", i, outs, e); end
      end
      total++;
      if ({c0, c1, c2, c3} !== {prev[0], prev[3:1]} || f0 !== (c0 | c2) || f1 !== (c1 | c3)) begin
        bad++; $display("FAIL phase_seq[%0d] got=%b want=%b", i, {c0, c1, c2, c3}, {prev[0], prev[3:1]});
      end
      prev = {c0, c1, c2, c3};
    end
  endtask

  task automatic test_rfsh_switch();
    logic [9:0] e;
    logic [1:0] pt;
    int nchg = 0;
    pt = turbo;
    turbo_req = 2'b10;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); total++;
        if (outs !== e) begin bad++; $display("FAIL rfsh_switch[%0d] got=%b want=%b", i, outs, e); end
      end
      if (turbo_chg) nchg++;
      if (turbo !== pt) begin
        total++;
        if (!c0) begin bad++; $display("FAIL rfsh_mid_period c0 got=%b want=1", c0); end
      end
      pt = turbo;
      if (i == 2) rfsh_n = 1'b0;
      if (i == 8) rfsh_n = 1'b1;
    end
    total++;
    if (turbo !== 2'b10 || nchg != 1 || turbo_busy !== 1'b0) begin
      bad++; $display("FAIL rfsh_result turbo=%b chg=%0d busy=%b want 10/1/0", turbo, nchg, turbo_busy);
    end
  endtask

  task automatic test_timeout();
    logic [9:0] e;
    int nchg = 0;
    int at = -1;
    turbo_req = 2'b01;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); total++;
        if (outs !== e) begin bad++; $display("FAIL timeout[%0d] got=%b want=%b", i, outs, e); end
      end
      if (turbo_chg) begin nchg++; at = i; end
    end
    total++;
    if (turbo !== 2'b01 || nchg != 1 || at < 33 || at > 36) begin
      bad++; $display("FAIL timeout_result turbo=%b chg=%0d at=%0d want 01/1/33..36", turbo, nchg, at);
    end
    // Withdraw a pending request before its timeout expires.
    nchg = 0;
    turbo_req = 2'b00;
    for (int i = 0; i < 62; i++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); total++;
        if (outs !== e) begin bad++; $display("FAIL withdraw[%0d] got=%b want=%b", i, outs, e); end
      end
      if (turbo_chg) nchg++;
      if (i == 11) turbo_req = 2'b01;
    end
    total++;
    if (turbo !== 2'b01 || nchg != 0 || turbo_busy !== 1'b0) begin
      bad++; $display("FAIL withdraw_result turbo=%b chg=%0d busy=%b want 01/0/0", turbo, nchg, turbo_busy);
    end
  endtask

  task automatic test_latest_wins();
    logic [9:0] e;
    int nchg = 0;
    int after = -1;
    logic armed_chg = 1'b0;
    turbo_req = 2'b10;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); total++;
        if (outs !== e) begin bad++; $display("FAIL latest[%0d] got=%b want=%b", i, outs, e); end
      end
      if (turbo_chg) begin nchg++; after = 0; end
      else if (after >= 0) after++;
      if (after == 2) begin
        total++;
        if (turbo_busy !== 1'b1) begin bad++; $display("FAIL rebusy got=%b want=1", turbo_busy); end
      end
      if (i == 3) turbo_req = 2'b11;
      if (i == 5) rfsh_n = 1'b0;
      if (i == 10) rfsh_n = 1'b1;
      if (m_st == 2 && !armed_chg) begin turbo_req = 2'b00; armed_chg = 1'b1; end
    end
    total++;
    if (turbo !== 2'b11 || nchg != 1 || turbo_busy !== 1'b1 || !armed_chg) begin
      bad++; $display("FAIL latest_result turbo=%b chg=%0d busy=%b want 11/1/1", turbo, nchg, turbo_busy);
    end
    // Let the re-detected request settle via a refresh.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); total++;
        if (outs !== e) begin bad++; $display("FAIL settle[%0d] got=%b want=%b", i, outs, e); end
      end
      if (i == 2) rfsh_n = 1'b0;
      if (i == 7) rfsh_n = 1'b1;
    end
    total++;
    if (turbo !== 2'b00 || turbo_busy !== 1'b0) begin
      bad++; $display("FAIL settle_result turbo=%b busy=%b want 00/0", turbo, turbo_busy);
    end
  endtask

  task automatic test_reset_in_arm();
    logic [9:0] e;
    int n = 0;
    int nchg = 0;
    logic hit = 1'b0;
    turbo_req = 2'b10;
    while (!hit && n < 40) begin
      @(negedge clk);
      n++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); total++;
        if (outs !== e) begin bad++; $display("FAIL arm_wait[%0d] got=%b want=%b", n, outs, e); end
      end
      if (m_st == 1 && m_c[0] && rfsh_n) rfsh_n = 1'b0;
      else if (m_st == 2 && !m_c[3]) hit = 1'b1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL arm_reached got=0 want=1"); end
    rfsh_n = 1'b1;
    rst_n = 1'b0;
    turbo_req = TR;
    #1;
    total++;
    if (outs !== {6'b0, TR, 2'b00}) begin
      bad++; $display("FAIL async_reset got=%b want=%b", outs, {6'b0, TR, 2'b00});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); total++;
        if (outs !== e) begin bad++; $display("FAIL post_reset[%0d] got=%b want=%b", i, outs, e); end
      end
      if (turbo_chg) nchg++;
    end
    total++;
    if (nchg != 0 || turbo !== TR || turbo_busy !== 1'b0) begin
      bad++; $display("FAIL post_reset_result turbo=%b chg=%0d busy=%b want %b/0/0", turbo, nchg, turbo_busy, TR);
    end
  endtask

  task automatic test_rfsh_no_req();
    logic [9:0] e;
    turbo_req = turbo;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); total++;
        if (outs !== e) begin bad++; $display("FAIL idle_rfsh[%0d] got=%b want=%b", i, outs, e); end
      end
      total++;
      if (turbo_busy !== 1'b0 || turbo_chg !== 1'b0 || turbo !== TR) begin
        bad++; $display("FAIL idle_quiet[%0d] busy=%b chg=%b turbo=%b want 0/0/%b", i, turbo_busy, turbo_chg, turbo, TR);
      end
      if (i == 1) rfsh_n = 1'b0;
      if (i == 7) rfsh_n = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0; turbo_req = TR; rfsh_n = 1'b1;
    test_reset();
    test_phase();
    test_rfsh_switch();
    test_timeout();
    test_latest_wins();
    test_reset_in_arm();
    test_rfsh_no_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
